// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmit master.
package i2s_pkg;

  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned WLEN_W   = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;

  // Frame configuration captured on IDLE -> RUN and held for the whole run
  typedef struct packed {
    logic [WLEN_W-1:0] wordlen;
    logic              lsb_first;
  } i2s_cfg_t;

endpackage

// File: rtl/i2s_tx_clkgen.sv
// SCK divider: half-period counter, registered SCK and a falling-event strobe
// asserted in the same cycle as the 1->0 toggle.
module i2s_tx_clkgen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] clkdiv,
  output logic             sck,
  output logic             fall_c
);

  logic [DIV_W-1:0] cnt_q;
  logic             tc_c;

  assign tc_c   = run && (cnt_q == clkdiv);
  assign fall_c = tc_c && sck;

  // Counter and SCK are parked at zero whenever the block is not running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck   <= 1'b0;
    end else if (!run) begin
      cnt_q <= '0;
      sck   <= 1'b0;
    end else if (tc_c) begin
      cnt_q <= '0;
      sck   <= ~sck;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_tx_master.sv
// I2S transmit master: one-entry sample hold, SCK generation and a
// left/right serializer with the standard one-bit word-select delay.
module i2s_tx_master
  import i2s_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic                sys_clk_i,
  input  logic                rstn_i,
  input  logic                cfg_en_i,
  input  logic [DIV_W-1:0]    cfg_clkdiv_i,
  input  logic [WLEN_W-1:0]   cfg_wordlen_i,
  input  logic                cfg_lsb_first_i,
  input  logic [SAMPLE_W-1:0] data_i,
  input  logic                data_valid_i,
  output logic                data_ready_o,
  output logic                sck_o,
  output logic                ws_o,
  output logic                sd_o,
  output logic                underrun_o
);

  i2s_state_e          state_q, state_d;
  logic                start_c, stop_c, load_c, accept_c, fall_c, run_c;
  i2s_cfg_t            cfg_q;
  logic [DIV_W-1:0]    clkdiv_q;
  logic                hold_full_q;
  logic [SAMPLE_W-1:0] hold_q, shift_q, word_c;
  logic [WLEN_W-1:0]   bit_cnt_q;
  logic                stop_q, ws_q, sd_q, underrun_q;

  assign run_c        = (state_q == ST_RUN);
  assign accept_c     = data_valid_i && !hold_full_q;
  assign load_c       = fall_c && !stop_q && (bit_cnt_q == '0);
  assign data_ready_o = !hold_full_q;
  assign ws_o         = ws_q;
  assign sd_o         = sd_q;
  assign underrun_o   = underrun_q;

  i2s_tx_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk    (sys_clk_i),
    .rst_n  (rstn_i),
    .run    (run_c),
    .clkdiv (clkdiv_q),
    .sck    (sck_o),
    .fall_c (fall_c)
  );

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    stop_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_en_i && hold_full_q) begin
          state_d = ST_RUN;
          start_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (fall_c && stop_q) begin
          state_d = ST_IDLE;
          stop_c  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word feeding the serializer: fresh sample (or zeros) on slot load, else the shifter
  always_comb begin
    word_c = shift_q;
    if (bit_cnt_q == '0) word_c = hold_full_q ? hold_q : '0;
  end

  // A sample accepted during a load lands after it, so it waits for the next slot
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      if (load_c) hold_full_q <= 1'b0;
      if (accept_c) begin
        hold_full_q <= 1'b1;
        hold_q      <= data_i;
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg_q      <= '0;
      clkdiv_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      stop_q     <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (start_c) begin
        cfg_q.wordlen   <= cfg_wordlen_i;
        cfg_q.lsb_first <= cfg_lsb_first_i;
        clkdiv_q        <= cfg_clkdiv_i;
        bit_cnt_q       <= '0;
        shift_q         <= '0;
        stop_q          <= 1'b0;
        ws_q            <= 1'b0;
        sd_q            <= 1'b0;
      end else if (stop_c) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
        stop_q    <= 1'b0;
        ws_q      <= 1'b0;
        sd_q      <= 1'b0;
      end else if (fall_c) begin
        underrun_q <= load_c && !hold_full_q;
        sd_q       <= cfg_q.lsb_first ? word_c[0] : word_c[cfg_q.wordlen];
        shift_q    <= cfg_q.lsb_first ? (word_c >> 1) : (word_c << 1);
        if (bit_cnt_q == cfg_q.wordlen) begin
          // Last bit of the slot: WS flips now; enable is sampled at the end of the right slot
          bit_cnt_q <= '0;
          ws_q      <= ~ws_q;
          if (ws_q) stop_q <= !cfg_en_i;
        end else begin
          bit_cnt_q <= bit_cnt_q + WLEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Scoreboard bench for i2s_tx_master: expected serial bits are queued from a
// frame-level model and checked by a monitor at every SCK falling event.
module tb_i2s_tx_master;

  localparam int unsigned DIV_W = 16;

  logic             sys_clk_i       = 1'b0;
  logic             rstn_i          = 1'b1;
  logic             cfg_en_i        = 1'b0;
  logic [DIV_W-1:0] cfg_clkdiv_i    = '0;
  logic [4:0]       cfg_wordlen_i   = 5'd7;
  logic             cfg_lsb_first_i = 1'b0;
  logic [31:0]      data_i          = '0;
  logic             data_valid_i    = 1'b0;
  logic             data_ready_o, sck_o, ws_o, sd_o, underrun_o;

  i2s_tx_master #(.DIV_W(DIV_W)) dut (
    .sys_clk_i       (sys_clk_i),
    .rstn_i          (rstn_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_clkdiv_i    (cfg_clkdiv_i),
    .cfg_wordlen_i   (cfg_wordlen_i),
    .cfg_lsb_first_i (cfg_lsb_first_i),
    .data_i          (data_i),
    .data_valid_i    (data_valid_i),
    .data_ready_o    (data_ready_o),
    .sck_o           (sck_o),
    .ws_o            (ws_o),
    .sd_o            (sd_o),
    .underrun_o      (underrun_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  typedef struct {
    bit ws;
    bit sd;
    int per;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] feeder[$];
  logic [31:0] model_q[$];
  logic [31:0] preset[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc       = 0;
  int fall_cnt  = 0;
  int un_cnt    = 0;
  int last_fall = 0;
  bit prev_sck  = 1'b0;
  bit mon_en    = 1'b1;
  bit acc       = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Producer: offers the feeder head; pops once the DUT has taken it
  always @(negedge sys_clk_i) begin
    if (!rstn_i) acc = 1'b0;
    else if (acc && feeder.size() > 0) void'(feeder.pop_front());
    data_valid_i = rstn_i && (feeder.size() > 0);
    data_i       = (feeder.size() > 0) ? feeder[0] : '0;
    acc          = data_valid_i && data_ready_o;
  end

  // Monitor: one scoreboard entry per SCK falling event
  always @(negedge sys_clk_i) begin
    exp_t e;
    cyc++;
    if (prev_sck && !sck_o && rstn_i) begin
      fall_cnt++;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sck_fall", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ws_bit", int'(ws_o), int'(e.ws));
          chk("sd_bit", int'(sd_o), int'(e.sd));
          if (e.per != 0) chk("sck_period", cyc - last_fall, e.per);
        end
      end
      last_fall = cyc;
    end
    if (underrun_o) un_cnt++;
    prev_sck = sck_o;
  end

  // One enable-to-IDLE run of nfr frames with latched config (c, wl, lsb)
  task automatic run_session(input int c, input int wl, input bit lsb, input int nfr,
                             input int nnew, input bit chg);
    logic [31:0] w;
    exp_t        e;
    int          exp_un, un0, f0, budget, thr;
    bit          ok;
    exp_un = 0;
    for (int i = 0; i < nnew; i++) begin
      w = (preset.size() > 0) ? preset.pop_front() : $urandom();
      feeder.push_back(w);
      model_q.push_back(w);
    end
    for (int s = 0; s < 2 * nfr; s++) begin
      if (model_q.size() > 0) w = model_q.pop_front();
      else begin
        w = '0;
        exp_un++;
      end
      for (int b = 0; b <= wl; b++) begin
        e.sd  = lsb ? w[b] : w[wl-b];
        e.ws  = (s % 2 == 0) ? (b == wl) : (b != wl);
        e.per = (s == 0 && b == 0) ? 0 : 2 * (c + 1);
        exp_q.push_back(e);
      end
    end
    e.ws = 1'b0; e.sd = 1'b0; e.per = 2 * (c + 1);
    exp_q.push_back(e);

    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge sys_clk_i);
      ok = !data_ready_o;
    end
    chk("hold_filled", int'(ok), 1);
    un0 = un_cnt;
    f0  = fall_cnt;
    cfg_clkdiv_i    = DIV_W'(c);
    cfg_wordlen_i   = 5'(wl);
    cfg_lsb_first_i = lsb;
    cfg_en_i        = 1'b1;
    @(negedge sys_clk_i);
    chk("delay_bit_sd", int'(sd_o), 0);
    chk("delay_bit_ws", int'(ws_o), 0);
    if (chg) begin
      cfg_clkdiv_i    = DIV_W'(5);
      cfg_wordlen_i   = 5'd31;
      cfg_lsb_first_i = !lsb;
    end
    budget = (2 * nfr * (wl + 1) + 2) * 2 * (c + 1) + 50;
    if (nfr == 1) cfg_en_i = 1'b0;
    else begin
      thr = 2 * (wl + 1) * (nfr - 1) + 1;
      ok  = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
        @(negedge sys_clk_i);
        ok = (fall_cnt - f0) >= thr;
      end
      chk("reached_last_frame", int'(ok), 1);
      cfg_en_i = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge sys_clk_i);
      ok = (exp_q.size() == 0);
    end
    chk("stream_complete", int'(ok), 1);
    if (!ok) exp_q.delete();
    repeat (4 * (c + 1) + 4) @(negedge sys_clk_i);
    chk("idle_sck", int'(sck_o), 0);
    chk("idle_ws", int'(ws_o), 0);
    chk("idle_sd", int'(sd_o), 0);
    chk("underrun_pulses", un_cnt - un0, exp_un);
    chk("ready_after_stop", int'(data_ready_o), int'(model_q.size() == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    int f0;
    #2 rstn_i = 1'b0;
    #1;
    chk("reset_ready", int'(data_ready_o), 1);
    chk("reset_sck", int'(sck_o), 0);
    chk("reset_ws", int'(ws_o), 0);
    chk("reset_sd", int'(sd_o), 0);
    chk("reset_underrun", int'(underrun_o), 0);
    repeat (3) @(negedge sys_clk_i);
    #1 rstn_i = 1'b1;
    @(negedge sys_clk_i);

    preset.push_back(32'h0000A5A5);
    preset.push_back(32'h00003C3C);
    run_session(1, 15, 1'b0, 1, 2, 1'b0);
    preset.push_back(32'h00000001);
    run_session(0, 7, 1'b1, 1, 2, 1'b0);
    run_session(2, 11, 1'b0, 1, 1, 1'b0);
    run_session(int'($urandom_range(0, 2)), int'($urandom_range(7, 31)),
                1'($urandom_range(0, 1)), 2, 4, 1'b0);
    run_session(1, 8, 1'b1, 1, 3, 1'b0);
    run_session(0, 9, 1'b0, 2, 3, 1'b1);
    run_session(5, 7, 1'b1, 1, 2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      int nf;
      nf = int'($urandom_range(1, 2));
      run_session(int'($urandom_range(0, 3)), int'($urandom_range(7, 31)),
                  1'($urandom_range(0, 1)), nf, int'($urandom_range(1, 2 * nf)), 1'b0);
    end

    // Reset while SCK is high in the middle of a slot
    mon_en = 1'b0;
    feeder.push_back($urandom());
    feeder.push_back($urandom());
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge sys_clk_i);
      ok = !data_ready_o;
    end
    cfg_clkdiv_i  = DIV_W'(3);
    cfg_wordlen_i = 5'd15;
    cfg_en_i      = 1'b1;
    f0 = fall_cnt;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge sys_clk_i);
      ok = (fall_cnt - f0) >= 3 && sck_o;
    end
    chk("reached_mid_slot", int'(ok), 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("abort_sck", int'(sck_o), 0);
    chk("abort_ws", int'(ws_o), 0);
    chk("abort_sd", int'(sd_o), 0);
    chk("abort_underrun", int'(underrun_o), 0);
    chk("abort_ready", int'(data_ready_o), 1);
    feeder.delete();
    model_q.delete();
    exp_q.delete();
    @(negedge sys_clk_i);
    #1 rstn_i = 1'b1;
    mon_en = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge sys_clk_i);
      if (sck_o) seen = 1'b1;
    end
    chk("no_sck_after_reset", int'(seen), 0);
    chk("ready_after_reset", int'(data_ready_o), 1);
    cfg_en_i = 1'b0;
    @(negedge sys_clk_i);
    run_session(1, 7, 1'b0, 1, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2s_tx_master.md
I2S_TX_MASTER -- requirements
Module: i2s_tx_master

Interface
REQ-001 Parameter DIV_W, default 16, width of SCK divider config and counter.
REQ-002 sys_clk_i  in  1  single clock; all logic on rising edge.
REQ-003 rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 cfg_en_i  in  1  enable; 1 = run, 0 = stop at frame end.
REQ-005 cfg_clkdiv_i  in  DIV_W  SCK half-period in sys_clk cycles, minus 1.
REQ-006 cfg_wordlen_i  in  5  bits per channel slot minus 1; legal 7..31.
REQ-007 cfg_lsb_first_i  in  1  1 = serialize LSB first, 0 = MSB first.
REQ-008 data_i  in  32  sample word, right-aligned in bits [wordlen:0].
REQ-009 data_valid_i  in  1  sample valid.
REQ-010 data_ready_o  out  1  sample accepted when valid and ready are both high.
REQ-011 sck_o  out  1  serial bit clock to pad.
REQ-012 ws_o  out  1  word select; 0 = left, 1 = right.
REQ-013 sd_o  out  1  serial data to pad.
REQ-014 underrun_o  out  1  one-cycle pulse when a slot starts with no sample buffered.

Function
REQ-015 The block SHALL have states IDLE and RUN.
REQ-016 IDLE -> RUN when cfg_en_i=1 and the hold register is full; cfg_clkdiv_i, cfg_wordlen_i and cfg_lsb_first_i SHALL be latched on that transition and ignored while in RUN.
REQ-017 The hold register is one entry; data_ready_o SHALL equal NOT(hold full), in every state.
REQ-018 Divider counter runs 0..clkdiv in RUN; at terminal count it SHALL wrap to 0 and toggle sck_o; SCK period = 2*(clkdiv+1) cycles; clkdiv=0 toggles every cycle.
REQ-019 All sd_o/ws_o updates SHALL occur only on SCK falling events (sck_o 1->0) in the same cycle as the toggle.
REQ-020 On entering RUN: sck_o=0, ws_o=0, sd_o=0, and this counts as the delay bit of the left slot.
REQ-021 The first falling event of a slot SHALL load the shift register from the hold register, emptying it, and drive the first bit.
REQ-022 If the hold register is empty at slot load, the slot SHALL transmit zeros and underrun_o SHALL pulse once.
REQ-023 Bit counter counts 0..wordlen per slot; on the falling event that drives bit index wordlen (the last bit), ws_o SHALL toggle simultaneously (one-bit I2S delay).
REQ-024 MSB-first drives data bit wordlen down to bit 0; LSB-first drives bit 0 up to bit wordlen.
REQ-025 cfg_en_i is sampled at the falling event driving the last bit of the right slot; if 0, the next falling event SHALL enter IDLE: sck_o, ws_o, sd_o = 0, counters cleared.
REQ-026 Hold register contents SHALL be kept across RUN -> IDLE.
REQ-027 A sample accepted in the same cycle as a slot load SHALL NOT be consumed by that load; it fills the hold register for the next slot.

Reset
REQ-028 Asserting rstn_i SHALL immediately force state IDLE, hold register empty, counters 0, and sck_o, ws_o, sd_o, underrun_o = 0; data_ready_o = 1.
REQ-029 Reset mid-frame SHALL abort the frame with no further SCK edges until re-enabled.

Structure
REQ-030 Package i2s_pkg SHALL hold the constants for sample width (32) and word-length field width (5) and the typedef of the latched config struct.
REQ-031 The SCK divider SHALL be a sub-module i2s_tx_clkgen producing sck_o and a one-cycle falling-event strobe.

Verification
REQ-032 clkdiv=1, wordlen=15, MSB-first, samples 0xA5A5 and 0x3C3C -> SCK period 4 cycles; ws_o low 16 SCK periods; sd_o = 0 delay bit then 1010010110100101; ws_o rises with the last left bit.
REQ-033 wordlen=7, LSB-first, left sample 0x01 -> first data bit after the delay bit = 1, then seven 0s.
REQ-034 Valid withheld after the first sample -> right slot all zeros, underrun_o exactly one pulse at the right-slot load.
REQ-035 cfg_en_i dropped mid-left-slot -> right slot completes, one further falling event, then IDLE with sck_o = ws_o = sd_o = 0.
REQ-036 rstn_i asserted mid-slot with clkdiv=3 -> all outputs 0 in the same cycle; data_ready_o = 1.
REQ-037 cfg_clkdiv_i changed 0->5 during RUN -> SCK period stays 2 cycles until the next IDLE -> RUN entry.
